// File: rtl/ascii_console_ctrl_pkg.sv
// Shared constants, opcodes and state encoding for the ASCII console controller.
// Pure definitions, no logic latency.
// No flow control of its own; consumed by the controller and its fill sequencer.
package ascii_console_ctrl_pkg;

  // Text geometry of the VGA character display
  localparam int CON_ROWS    = 30;
  localparam int CON_COLS    = 80;
  localparam int CON_ROW_BIT = 5;
  localparam int CON_COL_BIT = 7;

  // Character written by every clear operation (space)
  localparam logic [7:0] CON_FILL_CHAR = 8'h20;

  // Control characters interpreted by PUTC
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;

  typedef enum logic [1:0] {
    CON_PUTC    = 2'b00,
    CON_CLEAR   = 2'b01,
    CON_SETCUR  = 2'b10,
    CON_WRITEAT = 2'b11
  } con_op_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_CLR_SCREEN = 2'b01,
    ST_CLR_ROW    = 2'b10
  } con_state_t;

  // Characters that PUTC stores in the text RAM
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/ascii_fill_seq.sv
// Row/column fill counter walking one text row or the whole screen, one cell per cycle.
// First cell is presented combinationally in the start cycle; done pulses the cycle after the last cell.
// No backpressure: once started it emits a cell every cycle until finished or reset.
module ascii_fill_seq #(
  parameter int ROWS    = 30,
  parameter int COLS    = 80,
  parameter int ROW_BIT = 5,
  parameter int COL_BIT = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               single_row,
  input  logic [ROW_BIT-1:0] base_row,
  output logic               wr,
  output logic [ROW_BIT-1:0] row,
  output logic [COL_BIT-1:0] col,
  output logic               done
);

  localparam logic [ROW_BIT-1:0] LAST_ROW = ROW_BIT'(ROWS - 1);
  localparam logic [COL_BIT-1:0] LAST_COL = COL_BIT'(COLS - 1);

  logic               active;
  logic               single_q;
  logic [ROW_BIT-1:0] row_cnt;
  logic [COL_BIT-1:0] col_cnt;
  logic               single_cur;
  logic               last_col;
  logic               last;

  // Current cell: the start cycle uses the launch position directly so no cycle is lost
  always_comb begin
    wr         = start | active;
    row        = start ? (single_row ? base_row : '0) : row_cnt;
    col        = start ? '0 : col_cnt;
    single_cur = start ? single_row : single_q;
    last_col   = (col == LAST_COL);
    last       = last_col && (single_cur || (row == LAST_ROW));
  end

  // Advance the counter; the column wraps at COLS-1 so no off-screen address is produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      single_q <= 1'b0;
      row_cnt  <= '0;
      col_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      done <= wr && last;
      if (wr) begin
        active   <= !last;
        single_q <= single_cur;
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= row + 1'b1;
        end else begin
          col_cnt <= col + 1'b1;
          row_cnt <= row;
        end
      end
    end
  end

endmodule

// File: rtl/ascii_console_ctrl.sv
// Console command front end sequencing all writes into the ASCII text RAM, owning the cursor.
// Command writes appear one cycle after acceptance; fills write one cell per cycle.
// cmd_ready is low during row/screen fills, holding the requester off without loss.
module ascii_console_ctrl
  import ascii_console_ctrl_pkg::*;
#(
  parameter int         ROWS      = CON_ROWS,
  parameter int         COLS      = CON_COLS,
  parameter int         ROW_BIT   = CON_ROW_BIT,
  parameter int         COL_BIT   = CON_COL_BIT,
  parameter logic [7:0] FILL_CHAR = CON_FILL_CHAR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [7:0]                 cmd_data,
  input  logic [ROW_BIT-1:0]         cmd_row,
  input  logic [COL_BIT-1:0]         cmd_col,
  output logic                       ram_we,
  output logic [ROW_BIT+COL_BIT-1:0] ram_addr,
  output logic [7:0]                 ram_wdata,
  output logic [ROW_BIT-1:0]         cursor_row,
  output logic [COL_BIT-1:0]         cursor_col,
  output logic                       busy
);

  localparam int                 AW       = ROW_BIT + COL_BIT;
  localparam logic [ROW_BIT-1:0] LAST_ROW = ROW_BIT'(ROWS - 1);
  localparam logic [COL_BIT-1:0] LAST_COL = COL_BIT'(COLS - 1);

  con_state_t         state, state_nxt;
  con_op_t            op;
  logic               accept;
  logic               pend, pend_nxt;
  logic               we_nxt;
  logic [AW-1:0]      addr_nxt;
  logic [7:0]         wdata_nxt;
  logic [ROW_BIT-1:0] crow_nxt, adv_row;
  logic [COL_BIT-1:0] ccol_nxt, col_dec;
  logic               fill_start, fill_single;
  logic [ROW_BIT-1:0] fill_base;
  logic               fill_wr, fill_done;
  logic [ROW_BIT-1:0] fill_row;
  logic [COL_BIT-1:0] fill_col;

  assign op        = con_op_t'(cmd_op);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign adv_row   = (cursor_row == LAST_ROW) ? '0 : cursor_row + 1'b1;
  assign col_dec   = cursor_col - 1'b1;

  ascii_fill_seq #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .ROW_BIT (ROW_BIT),
    .COL_BIT (COL_BIT)
  ) u_fill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (fill_start),
    .single_row (fill_single),
    .base_row   (fill_base),
    .wr         (fill_wr),
    .row        (fill_row),
    .col        (fill_col),
    .done       (fill_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: fills are entered from command decode and left once the last cell is on the bus
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op == CON_CLEAR) begin
            state_nxt = ST_CLR_SCREEN;
          end else if (op == CON_PUTC &&
                       ((cmd_data == CH_LF) ||
                        (is_printable(cmd_data) && cursor_col == LAST_COL))) begin
            state_nxt = ST_CLR_ROW;
          end
        end
      end
      ST_CLR_SCREEN, ST_CLR_ROW: begin
        if (fill_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered RAM port and cursor, plus fill launch
  always_comb begin
    we_nxt      = 1'b0;
    addr_nxt    = ram_addr;
    wdata_nxt   = ram_wdata;
    crow_nxt    = cursor_row;
    ccol_nxt    = cursor_col;
    pend_nxt    = pend;
    fill_start  = 1'b0;
    fill_single = 1'b1;
    fill_base   = cursor_row;

    // A wrapping printable char writes first; its row clear launches one cycle later
    if (state == ST_CLR_ROW && pend) begin
      fill_start = 1'b1;
      fill_base  = cursor_row;
      pend_nxt   = 1'b0;
    end

    if (accept) begin
      unique case (op)
        CON_PUTC: begin
          if (is_printable(cmd_data)) begin
            we_nxt    = 1'b1;
            addr_nxt  = {cursor_row, cursor_col};
            wdata_nxt = cmd_data;
            if (cursor_col == LAST_COL) begin
              ccol_nxt = '0;
              crow_nxt = adv_row;
              pend_nxt = 1'b1;
            end else begin
              ccol_nxt = cursor_col + 1'b1;
            end
          end else if (cmd_data == CH_LF) begin
            ccol_nxt   = '0;
            crow_nxt   = adv_row;
            fill_start = 1'b1;
            fill_base  = adv_row;
          end else if (cmd_data == CH_CR) begin
            ccol_nxt = '0;
          end else if (cmd_data == CH_BS && cursor_col != '0) begin
            ccol_nxt  = col_dec;
            we_nxt    = 1'b1;
            addr_nxt  = {cursor_row, col_dec};
            wdata_nxt = FILL_CHAR;
          end
        end
        CON_CLEAR: begin
          crow_nxt    = '0;
          ccol_nxt    = '0;
          fill_start  = 1'b1;
          fill_single = 1'b0;
        end
        CON_SETCUR: begin
          crow_nxt = (cmd_row > LAST_ROW) ? LAST_ROW : cmd_row;
          ccol_nxt = (cmd_col > LAST_COL) ? LAST_COL : cmd_col;
        end
        CON_WRITEAT: begin
          if (cmd_row <= LAST_ROW && cmd_col <= LAST_COL) begin
            we_nxt    = 1'b1;
            addr_nxt  = {cmd_row, cmd_col};
            wdata_nxt = cmd_data;
          end
        end
      endcase
    end

    // Fill cells never coincide with a command write, so they simply take the port
    if (fill_wr) begin
      we_nxt    = 1'b1;
      addr_nxt  = {fill_row, fill_col};
      wdata_nxt = FILL_CHAR;
    end
  end

  // Output and cursor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      pend       <= 1'b0;
    end else begin
      ram_we     <= we_nxt;
      ram_addr   <= addr_nxt;
      ram_wdata  <= wdata_nxt;
      cursor_row <= crow_nxt;
      cursor_col <= ccol_nxt;
      pend       <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_ascii_console_ctrl.sv
// Self-checking bench for ascii_console_ctrl: vector table, timed corner sequences, random commands.
// Expected RAM contents and cursor come from a cell-array model of the console rules.
// Commands wait on cmd_ready with bounded loops.
module tb_ascii_console_ctrl;

  localparam int         ROWS = 30;
  localparam int         COLS = 80;
  localparam int         RB   = 5;
  localparam int         CB   = 7;
  localparam logic [7:0] FILL = 8'h20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd0;
  logic [7:0]    cmd_data = 8'd0;
  logic [RB-1:0] cmd_row = '0;
  logic [CB-1:0] cmd_col = '0;
  logic          cmd_ready, ram_we, busy;
  logic [RB+CB-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic [RB-1:0] cursor_row;
  logic [CB-1:0] cursor_col;
  logic [RB-1:0] addr_row;
  logic [CB-1:0] addr_col;

  assign addr_row = ram_addr[CB +: RB];
  assign addr_col = ram_addr[CB-1:0];

  int n_checks = 0;
  int n_fail   = 0;
  int illegal  = 0;
  int m_row = 0, m_col = 0;
  bit [7:0] mram   [0:31][0:127];
  bit [7:0] shadow [0:31][0:127];

  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    int         r, c;
    bit         we;
    int         er, ec;
    logic [7:0] ed;
    int         crow, ccol;
  } vec_t;
  vec_t vt [15];

  always #5 clk = ~clk;

  ascii_console_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  // Capture every RAM write mid-cycle into a shadow text RAM
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      if (addr_row >= ROWS || addr_col >= COLS) illegal <= illegal + 1;
      shadow[addr_row][addr_col] <= ram_wdata;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference console model on a plain cell array
  task automatic m_advance();
    m_row = (m_row + 1) % ROWS;
    for (int c = 0; c < COLS; c++) mram[m_row][c] = FILL;
  endtask

  task automatic m_apply(input logic [1:0] op, input logic [7:0] d, input int r, input int c);
    case (op)
      2'd0: begin
        if (d >= 8'h20 && d <= 8'h7E) begin
          mram[m_row][m_col] = d;
          m_col++;
          if (m_col == COLS) begin
            m_col = 0;
            m_advance();
          end
        end else if (d == 8'h0A) begin
          m_col = 0;
          m_advance();
        end else if (d == 8'h0D) begin
          m_col = 0;
        end else if (d == 8'h08 && m_col > 0) begin
          m_col--;
          mram[m_row][m_col] = FILL;
        end
      end
      2'd1: begin
        for (int rr = 0; rr < ROWS; rr++)
          for (int cc = 0; cc < COLS; cc++) mram[rr][cc] = FILL;
        m_row = 0;
        m_col = 0;
      end
      2'd2: begin
        m_row = (r > ROWS - 1) ? ROWS - 1 : r;
        m_col = (c > COLS - 1) ? COLS - 1 : c;
      end
      default: begin
        if (r < ROWS && c < COLS) mram[r][c] = d;
      end
    endcase
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!cmd_ready && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  // Issue one command; returns 1 time unit after the accepting edge
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input int r, input int c);
    wait_ready(3000);
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_row = RB'(r); cmd_col = CB'(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_apply(op, d, r, c);
  endtask

  initial begin
    int bad, gap, cnt, iter, clears, sel, rr, cc;
    logic [7:0] d;
    logic [7:0] ctl [5];

    vt[0]  = '{2'd0, 8'h41, 0, 0,    1'b1, 0, 0, 8'h41, 0, 1};
    vt[1]  = '{2'd0, 8'h42, 0, 0,    1'b1, 0, 1, 8'h42, 0, 2};
    vt[2]  = '{2'd2, 8'h00, 2, 79,   1'b0, 0, 0, 8'h00, 2, 79};
    vt[3]  = '{2'd2, 8'h00, 31, 127, 1'b0, 0, 0, 8'h00, 29, 79};
    vt[4]  = '{2'd2, 8'h00, 1, 3,    1'b0, 0, 0, 8'h00, 1, 3};
    vt[5]  = '{2'd0, 8'h0D, 0, 0,    1'b0, 0, 0, 8'h00, 1, 0};
    vt[6]  = '{2'd0, 8'h08, 0, 0,    1'b0, 0, 0, 8'h00, 1, 0};
    vt[7]  = '{2'd2, 8'h00, 1, 5,    1'b0, 0, 0, 8'h00, 1, 5};
    vt[8]  = '{2'd0, 8'h08, 0, 0,    1'b1, 1, 4, 8'h20, 1, 4};
    vt[9]  = '{2'd3, 8'h78, 30, 0,   1'b0, 0, 0, 8'h00, 1, 4};
    vt[10] = '{2'd3, 8'h78, 0, 80,   1'b0, 0, 0, 8'h00, 1, 4};
    vt[11] = '{2'd3, 8'h78, 1, 1,    1'b1, 1, 1, 8'h78, 1, 4};
    vt[12] = '{2'd0, 8'h01, 0, 0,    1'b0, 0, 0, 8'h00, 1, 4};
    vt[13] = '{2'd0, 8'h7F, 0, 0,    1'b0, 0, 0, 8'h00, 1, 4};
    vt[14] = '{2'd0, 8'h7E, 0, 0,    1'b1, 1, 4, 8'h7E, 1, 5};
    ctl[0] = 8'h0A; ctl[1] = 8'h0D; ctl[2] = 8'h08; ctl[3] = 8'h01; ctl[4] = 8'h7F;

    // Reset state
    #12;
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_cursor_row", cursor_row, 0);
    chk("rst_cursor_col", cursor_col, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle command table
    for (int i = 0; i < 15; i++) begin
      do_cmd(vt[i].op, vt[i].d, vt[i].r, vt[i].c);
      chk($sformatf("v%0d_we", i), ram_we, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("v%0d_addr_row", i), addr_row, vt[i].er);
        chk($sformatf("v%0d_addr_col", i), addr_col, vt[i].ec);
        chk($sformatf("v%0d_wdata", i), ram_wdata, vt[i].ed);
      end
      chk($sformatf("v%0d_cursor_row", i), cursor_row, vt[i].crow);
      chk($sformatf("v%0d_cursor_col", i), cursor_col, vt[i].ccol);
      chk($sformatf("v%0d_ready", i), cmd_ready, 1);
    end

    // Printable char at the last column, then the row clear of the next row
    do_cmd(2'd2, 8'h00, 2, 79);
    do_cmd(2'd0, 8'h5A, 0, 0);
    chk("wrap_we", ram_we, 1);
    chk("wrap_addr", ram_addr, {5'd2, 7'd79});
    chk("wrap_wdata", ram_wdata, 8'h5A);
    chk("wrap_cursor", {cursor_row, cursor_col}, {5'd3, 7'd0});
    chk("wrap_busy", busy, 1);
    bad = 0;
    for (int k = 0; k < COLS; k++) begin
      @(posedge clk); #1;
      if (!(ram_we && addr_row == 3 && addr_col == k && ram_wdata == FILL && !cmd_ready)) bad++;
    end
    chk("rowfill_bad_cycles", bad, 0);
    @(posedge clk); #1;
    chk("rowfill_ready_after", cmd_ready, 1);
    chk("rowfill_we_after", ram_we, 0);

    // Line feed on the last row wraps to row 0 and clears it from the next cycle
    do_cmd(2'd2, 8'h00, 29, 5);
    do_cmd(2'd0, 8'h0A, 0, 0);
    chk("lf_cursor", {cursor_row, cursor_col}, 0);
    chk("lf_first_fill", {ram_we, ram_addr, ram_wdata}, {1'b1, 12'd0, FILL});
    chk("lf_ready_low", cmd_ready, 0);
    bad = 0;
    for (int k = 1; k < COLS; k++) begin
      @(posedge clk); #1;
      if (!(ram_we && addr_row == 0 && addr_col == k && ram_wdata == FILL && !cmd_ready)) bad++;
    end
    chk("lf_fill_bad_cycles", bad, 0);
    @(posedge clk); #1;
    chk("lf_ready_after", cmd_ready, 1);

    // Full-screen clear with a PUTC held off until the fill completes
    do_cmd(2'd1, 8'h00, 0, 0);
    cmd_op = 2'd0; cmd_data = 8'h51; cmd_valid = 1'b1;
    cnt = 0; bad = 0; gap = 0; iter = 0;
    while (!cmd_ready && iter < 3000) begin
      if (ram_we) begin
        if (addr_row != cnt / COLS || addr_col != cnt % COLS || ram_wdata != FILL) bad++;
        cnt++;
      end else gap++;
      if (cursor_row != 0 || cursor_col != 0) bad++;
      @(posedge clk); #1;
      iter++;
    end
    chk("clear_write_count", cnt, ROWS * COLS);
    chk("clear_order_bad", bad, 0);
    chk("clear_gaps", gap, 0);
    chk("clear_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_apply(2'd0, 8'h51, 0, 0);
    chk("held_putc_write", {ram_we, ram_addr, ram_wdata}, {1'b1, 12'd0, 8'h51});
    chk("held_putc_cursor", {cursor_row, cursor_col}, {5'd0, 7'd1});

    // Random command stream against the model
    clears = 0;
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 99);
      rr = $urandom_range(0, 31);
      cc = ($urandom_range(0, 1) == 1) ? $urandom_range(70, 127) : $urandom_range(0, 127);
      if (sel < 60) begin
        d = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(32, 126)) : ctl[$urandom_range(0, 4)];
        do_cmd(2'd0, d, 0, 0);
      end else if (sel < 75) begin
        do_cmd(2'd2, 8'h00, rr, cc);
      end else if (sel < 97 || clears >= 2) begin
        do_cmd(2'd3, 8'($urandom_range(32, 126)), rr, cc);
      end else begin
        clears++;
        do_cmd(2'd1, 8'h00, 0, 0);
      end
      wait_ready(3000);
      chk($sformatf("rand%0d_cursor", i), {cursor_row, cursor_col}, {RB'(m_row), CB'(m_col)});
    end

    // Compare the captured RAM with the model
    @(negedge clk); #1;
    for (int r = 0; r < ROWS; r++) begin
      bad = 0;
      for (int c = 0; c < COLS; c++) if (shadow[r][c] != mram[r][c]) bad++;
      chk($sformatf("ram_row%0d_bad_cells", r), bad, 0);
    end
    chk("illegal_addresses", illegal, 0);

    // Reset in the middle of a screen clear
    do_cmd(2'd2, 8'h00, 7, 9);
    do_cmd(2'd1, 8'h00, 0, 0);
    repeat (99) @(posedge clk);
    #1;
    chk("midrst_we_before", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_cursor", {cursor_row, cursor_col}, 0);
    chk("midrst_addr", ram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gap = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ram_we) gap++;
    end
    chk("midrst_no_writes_after", gap, 0);
    chk("midrst_ready_after", cmd_ready, 1);
    chk("midrst_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
